// File: rtl/pwm_cfg_spi_if.sv
// SPI pin bundle between an external SPI master and the PWM configuration slave.
// Mode 0, MSB first; the slave only oversamples these pins, it never uses sclk_i as a clock.
interface pwm_cfg_spi_if;
    logic sclk_i;
    logic cs_ni;
    logic mosi_i;
    logic miso_o;

    modport master (output sclk_i, output cs_ni, output mosi_i, input miso_o);
    modport slave  (input sclk_i, input cs_ni, input mosi_i, output miso_o);
endinterface

// File: rtl/pwm_cfg_spi.sv
// SPI-slave configuration stage for the PWM: 16-bit frames write three shadow registers,
// and a commit command copies all shadows to the active outputs in a single cycle.
module pwm_cfg_spi #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RST_SET     = 8'd0,
    parameter logic [7:0] RST_CLR     = 8'd0,
    parameter logic [7:0] RST_RELOAD  = 8'd255
) (
    input  logic         clk_i,
    input  logic         res_ni,
    pwm_cfg_spi_if.slave spi,
    output logic [7:0]   set_thres_o,
    output logic [7:0]   clr_thres_o,
    output logic [7:0]   reload_o,
    output logic         commit_o
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic                   w_sclk;
    logic                   w_cs_n;
    logic                   w_mosi;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_fall;

    logic [4:0]             r_bit_cnt;
    logic [15:0]            r_rx;
    logic [7:0]             r_tx;
    logic                   r_miso;
    logic                   r_exec;
    logic                   r_load;

    logic [7:0]             r_set_sh;
    logic [7:0]             r_clr_sh;
    logic [7:0]             r_rel_sh;
    logic [7:0]             r_set_act;
    logic [7:0]             r_clr_act;
    logic [7:0]             r_rel_act;
    logic                   r_commit;
    logic [7:0]             w_rd_data;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_fall   = r_cs_d & ~w_cs_n;

    // cs_n synchronizer resets high so reset release never looks like a frame start.
    always_ff @(posedge clk_i or negedge res_ni) begin
        if (!res_ni) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk_i};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi.cs_ni};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.mosi_i};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs_n;
        end
    end

    // After 8 bits the command byte sits in r_rx[7:0], so the address is r_rx[2:0].
    always_comb begin
        w_rd_data = 8'h00;
        case (r_rx[2:0])
            3'd0:    w_rd_data = r_set_sh;
            3'd1:    w_rd_data = r_clr_sh;
            3'd2:    w_rd_data = r_rel_sh;
            3'd4:    w_rd_data = r_set_act;
            3'd5:    w_rd_data = r_clr_act;
            3'd6:    w_rd_data = r_rel_act;
            default: w_rd_data = 8'h00;
        endcase
    end

    // Deasserted cs_n holds the counter at zero, which is also how an aborted frame is dropped.
    always_ff @(posedge clk_i or negedge res_ni) begin
        if (!res_ni) begin
            r_bit_cnt <= 5'd0;
            r_rx      <= 16'h0000;
            r_tx      <= 8'h00;
            r_miso    <= 1'b0;
            r_exec    <= 1'b0;
            r_load    <= 1'b0;
        end else begin
            r_exec <= 1'b0;
            r_load <= 1'b0;
            if (w_cs_n) begin
                r_bit_cnt <= 5'd0;
                r_miso    <= 1'b0;
            end else if (w_cs_fall) begin
                r_bit_cnt <= 5'd0;
                r_rx      <= 16'h0000;
                r_miso    <= 1'b0;
            end else begin
                if (w_sclk_rise && r_bit_cnt != 5'd16) begin
                    r_rx      <= {r_rx[14:0], w_mosi};
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                    r_exec    <= (r_bit_cnt == 5'd15);
                    r_load    <= (r_bit_cnt == 5'd7);
                end
                if (r_load) begin
                    r_tx <= w_rd_data;
                end else if (w_sclk_fall) begin
                    if (r_bit_cnt >= 5'd8 && r_bit_cnt != 5'd16) begin
                        r_miso <= r_tx[7];
                        r_tx   <= {r_tx[6:0], 1'b0};
                    end else begin
                        r_miso <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge res_ni) begin
        if (!res_ni) begin
            r_set_sh  <= RST_SET;
            r_clr_sh  <= RST_CLR;
            r_rel_sh  <= RST_RELOAD;
            r_set_act <= RST_SET;
            r_clr_act <= RST_CLR;
            r_rel_act <= RST_RELOAD;
            r_commit  <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            if (r_exec && r_rx[15]) begin
                case (r_rx[10:8])
                    3'd0: r_set_sh <= r_rx[7:0];
                    3'd1: r_clr_sh <= r_rx[7:0];
                    3'd2: r_rel_sh <= r_rx[7:0];
                    3'd3: begin
                        if (r_rx[0]) begin
                            r_set_act <= r_set_sh;
                            r_clr_act <= r_clr_sh;
                            r_rel_act <= r_rel_sh;
                            r_commit  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign set_thres_o = r_set_act;
    assign clr_thres_o = r_clr_act;
    assign reload_o    = r_rel_act;
    assign commit_o    = r_commit;
    assign spi.miso_o  = r_miso & ~w_cs_n;

endmodule

// File: doc/pwm_cfg_spi.md
Name: pwm_cfg_spi

Overview:
- SPI-slave configuration stage directly upstream of the PWM generator; drives its set-threshold, clear-threshold and reload inputs.
- Receives 16-bit frames from the external pins and writes three shadow registers.
- Copies all shadows to the active outputs atomically on a commit command, so the PWM never sees a half-updated configuration.
- SPI pins are oversampled in the clk_i domain; no second clock.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizer on sclk_i, cs_ni and mosi_i (minimum 2).
- RST_SET, 8'd0, reset value of set shadow and set_thres_o.
- RST_CLR, 8'd0, reset value of clr shadow and clr_thres_o.
- RST_RELOAD, 8'd255, reset value of reload shadow and reload_o.

Ports:
- clk_i  in  1  system clock; single clock domain.
- res_ni  in  1  asynchronous, active-low reset.
- sclk_i  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk_i.
- cs_ni  in  1  SPI chip select, active low, asynchronous.
- mosi_i  in  1  SPI data in, MSB first, asynchronous.
- miso_o  out  1  SPI data out; 0 whenever synchronized cs_n is high.
- set_thres_o  out  8  active set threshold to the PWM.
- clr_thres_o  out  8  active clear threshold to the PWM.
- reload_o  out  8  active reload value to the PWM.
- commit_o  out  1  one-cycle pulse in the cycle the active outputs change.

Behaviour:
- Reset (async assert, sync release):
  - shadows and actives take RST_* values.
  - miso_o=0, commit_o=0.
  - bit counter=0, frame idle.
- Sync and edge detect:
  - sclk_i, cs_ni and mosi_i each pass through SYNC_STAGES flops.
  - sclk rise/fall are detected from the last two synchronized samples.
  - Requirement: f_clk >= 4*f_sclk.
- Frame start: synchronized cs_n falling (high→low) clears the bit counter and the rx shift register.
- Bit sampling (cs_n low): on each detected sclk rise, shift mosi into rx, increment the bit counter (saturates at 16).
- Frame format, 16 bits:
  - bit15 = W (1 write, 0 read).
  - bits14:11 reserved, ignored.
  - bits10:8 = address.
  - bits7:0 = data (write) / don't-care (read).
- Address map:
  - 0 set shadow (R/W)
  - 1 clr shadow (R/W)
  - 2 reload shadow (R/W)
  - 3 control (W: bit0=1 → commit; reads 8'h00)
  - 4 active set (RO)
  - 5 active clr (RO)
  - 6 active reload (RO)
  - 7 reads 8'h00
- Writes:
  - Execute in the clk_i cycle after the 16th sclk rise is detected.
  - Writes to addresses 4–7 are ignored.
- Commit:
  - A write to address 3 with data bit0=1 copies all three shadows to the actives on the same cycle a shadow write would occur.
  - commit_o pulses high that cycle.
  - Data bit0=0 to address 3 is a no-op.
- Read:
  - After the 8th rise, the tx register loads the addressed value.
  - On the following sclk fall it drives tx[7]; each later fall shifts the next bit.
  - Total 8 data bits, MSB first.
  - During the command phase and after bit 16, miso_o=0.
- Abort:
  - cs_n rising before the 16th rise discards the frame: no write, no commit.
  - Bit counter resets; miso_o→0.
- Overlength: rises beyond 16 in the same frame are ignored; the write executes exactly once.
- Reset mid-frame: everything returns to reset values; the partial frame is lost.
- Actives change only on commit (or reset). Shadow writes never alter outputs directly.
- A read of addresses 0–2 returns the shadow, even if not yet committed.

Test Plan:
- Reset with no SPI activity → set_thres_o=0x00, clr_thres_o=0x00, reload_o=0xFF, miso_o=0, commit_o=0.
- Write frames 0x8010, 0x8180, 0x82C7, no commit → outputs unchanged (0x00/0x00/0xFF); read frames 0x0000, 0x0100, 0x0200 → miso returns 0x10, 0x80, 0xC7.
- Then write 0x8301 → one-cycle commit_o; set_thres_o=0x10, clr_thres_o=0x80, reload_o=0xC7 in the same cycle; read 0x0600 → 0xC7.
- Write 0x8055 aborted (cs_n high after 10 bits) → set shadow still 0x10 (read 0x0000 → 0x10); no commit_o.
- Frame 0x8033 followed by 4 extra sclk pulses before cs_n high → set shadow=0x33, written once; write 0x8300 → no commit_o, outputs unchanged.
- Assert res_ni low after 12 bits of 0x8301 → outputs return to 0x00/0x00/0xFF; next full frame 0x8301 commits reset-valued shadows; commit_o pulses.
